mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 132 +++++++++++++
 tb/tb_mdu_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit with architectural HI/LO registers and a
// fixed-latency IDLE/BUSY sequencer. Optional MADD/MSUB family under `MDU_MADD_EN`.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MADDU = 4'b1000;
  localparam logic [3:0] OP_MSUB  = 4'b1001;
  localparam logic [3:0] OP_MSUBU = 4'b1010;
`endif

  logic [0:0]  state;
  logic [15:0] cnt;
  logic [63:0] pend;

  logic [63:0] prod_s, prod_u;
  logic        signed_div;
  logic [31:0] dvd, dvs, dvs_safe, quo, rem, quo_out, rem_out;
  logic [63:0] div_res;
  logic        op_valid;
  logic        op_mt;
  logic [15:0] lat;
  logic [63:0] next_res;
  logic        accept;

  // Arithmetic is evaluated in the acceptance cycle; the busy period only
  // models latency before the result is committed.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'b0, A} * {32'b0, B};

    signed_div = (MDOp == OP_DIV);
    dvd      = (signed_div && A[31]) ? -A : A;
    dvs      = (signed_div && B[31]) ? -B : B;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    quo      = dvd / dvs_safe;
    rem      = dvd % dvs_safe;
    quo_out  = (signed_div && (A[31] ^ B[31])) ? -quo : quo;
    rem_out  = (signed_div && A[31]) ? -rem : rem;
    if (B == 32'd0)
      div_res = {A, 32'hFFFFFFFF};
    else
      div_res = {rem_out, quo_out};
  end

  always_comb begin
    op_valid = 1'b0;
    op_mt    = 1'b0;
    lat      = 16'(MULT_CYCLES - 1);
    next_res = {HI, LO};
    case (MDOp)
      OP_MULT:  begin op_valid = 1'b1; next_res = prod_s; end
      OP_MULTU: begin op_valid = 1'b1; next_res = prod_u; end
      OP_DIV, OP_DIVU: begin
        op_valid = 1'b1;
        lat      = 16'(DIV_CYCLES - 1);
        next_res = div_res;
      end
      OP_MTHI, OP_MTLO: begin op_valid = 1'b1; op_mt = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin op_valid = 1'b1; next_res = {HI, LO} + prod_s; end
      OP_MADDU: begin op_valid = 1'b1; next_res = {HI, LO} + prod_u; end
      OP_MSUB:  begin op_valid = 1'b1; next_res = {HI, LO} - prod_s; end
      OP_MSUBU: begin op_valid = 1'b1; next_res = {HI, LO} - prod_u; end
`endif
      default: ;
    endcase
  end

  assign accept = Start && !Cancel && (state == S_IDLE) && op_valid;
  assign Busy   = (state == S_BUSY);

  // HI/LO change only on MTHI/MTLO or when the busy countdown expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 16'd0;
      pend  <= 64'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_mt) begin
              if (MDOp == OP_MTHI)
                HI <= A;
              else
                LO <= A;
            end else begin
              pend  <= next_res;
              cnt   <= lat;
              state <= S_BUSY;
            end
          end
        end
        default: begin
          if (cnt == 16'd0) begin
            {HI, LO} <= pend;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq; expected values are hand-computed.
// Covers the MDU_MADD_EN build when the macro is defined, the plain build otherwise.
module tb_mdu_seq;

  localparam logic [3:0] OP_NONE  = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADDU = 4'b1000;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MSUB  = 4'b1001;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDOp;
  logic        Start, Cancel;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int cycles;

  mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
    .Start(Start), .Cancel(Cancel), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge and hold for one full cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic st, input logic cn);
    @(negedge clk);
    MDOp = op; A = a; B = b; Start = st; Cancel = cn;
  endtask

  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    applyStimulus(op, a, b, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (Busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (Busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    checkOutput(tag, {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; A = '0; B = '0; MDOp = OP_NONE; Start = 1'b0; Cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_hilo", {HI, LO}, 64'd0);

    // MULT with hold check during the first busy cycle
    applyStimulus(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mult_busy_first", {63'd0, Busy}, 64'd1);
    checkOutput("mult_hold_hilo", {HI, LO}, 64'd0);
    cycles = 0;
    while (Busy && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
    checkOutput("mult_cycles", 64'(cycles), 64'd5);
    checkOutput("mult_hilo", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFE});

    runOp(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, cycles);
    checkOutput("multu_cycles", 64'(cycles), 64'd5);
    checkOutput("multu_hilo", {HI, LO}, {32'h00000001, 32'hFFFFFFFE});

    runOp(OP_DIV, 32'hFFFFFFF9, 32'h00000002, cycles);
    checkOutput("div_cycles", 64'(cycles), 64'd10);
    checkOutput("div_neg_hilo", {HI, LO}, {32'hFFFFFFFF, 32'hFFFFFFFD});

    runOp(OP_DIV, 32'h00000007, 32'hFFFFFFFE, cycles);
    checkOutput("div_negdivisor_hilo", {HI, LO}, {32'h00000001, 32'hFFFFFFFD});

    runOp(OP_DIVU, 32'h00000007, 32'h00000000, cycles);
    checkOutput("divu_zero_cycles", 64'(cycles), 64'd10);
    checkOutput("divu_zero_hilo", {HI, LO}, {32'h00000007, 32'hFFFFFFFF});

    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cycles);
    checkOutput("div_overflow_hilo", {HI, LO}, {32'h00000000, 32'h80000000});

    runOp(OP_DIVU, 32'hFFFFFFF9, 32'h00000002, cycles);
    checkOutput("divu_hilo", {HI, LO}, {32'h00000001, 32'h7FFFFFFC});

    // MTHI/MTLO complete in one cycle without Busy
    applyStimulus(OP_MTHI, 32'hAAAA5555, 32'd0, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mthi_busy", {63'd0, Busy}, 64'd0);
    checkOutput("mthi_hi", {32'd0, HI}, {32'd0, 32'hAAAA5555});
    applyStimulus(OP_MTLO, 32'h0BADF00D, 32'd0, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("mtlo_hilo", {HI, LO}, {32'hAAAA5555, 32'h0BADF00D});

    // Start+Cancel while idle is dropped
    applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b1, 1'b1);
    applyStimulus(OP_MULT, 32'd3, 32'd3, 1'b1, 1'b1);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("cancel_idle_busy", {63'd0, Busy}, 64'd0);
    checkOutput("cancel_idle_hilo", {HI, LO}, {32'hAAAA5555, 32'h0BADF00D});

    // Undefined opcode is NONE
    applyStimulus(4'b1011, 32'h11111111, 32'h2, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("undef_busy", {63'd0, Busy}, 64'd0);
    checkOutput("undef_hilo", {HI, LO}, {32'hAAAA5555, 32'h0BADF00D});

    // MTLO issued at busy cycle 2 of a MULT is ignored
    applyStimulus(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(OP_MTLO, 32'h12345678, 32'd0, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("start_while_busy_hold", {HI, LO}, {32'hAAAA5555, 32'h0BADF00D});
    waitIdle("start_while_busy_idle");
    checkOutput("start_while_busy_hilo", {HI, LO}, {32'h00000000, 32'h0000000C});

    // Cancel while busy does not abort
    applyStimulus(OP_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("cancel_busy_still", {63'd0, Busy}, 64'd1);
    waitIdle("cancel_busy_idle");
    checkOutput("cancel_busy_hilo", {HI, LO}, {32'h00000000, 32'h0000002A});

    // Reset at busy cycle 4 of DIV discards the pending result
    applyStimulus(OP_MTHI, 32'h55555555, 32'd0, 1'b1, 1'b0);
    applyStimulus(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_mid_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_mid_hilo", {HI, LO}, 64'd0);
    repeat (12) @(negedge clk);
    checkOutput("reset_no_late_write", {HI, LO}, 64'd0);
    checkOutput("reset_no_late_busy", {63'd0, Busy}, 64'd0);

    // Reset wins over a same-cycle Start
    applyStimulus(OP_MTHI, 32'h11111111, 32'd0, 1'b1, 1'b0);
    reset = 1'b1;
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("reset_priority_hi", {32'd0, HI}, 64'd0);

    // MADD-class behaviour depends on the build
    applyStimulus(OP_MTHI, 32'h00000000, 32'd0, 1'b1, 1'b0);
    applyStimulus(OP_MTLO, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    runOp(OP_MADDU, 32'd1, 32'd1, cycles);
    checkOutput("maddu_cycles", 64'(cycles), 64'd5);
    checkOutput("maddu_hilo", {HI, LO}, {32'h00000001, 32'h00000000});
    runOp(OP_MSUB, 32'd1, 32'd2, cycles);
    checkOutput("msub_hilo", {HI, LO}, {32'h00000000, 32'hFFFFFFFE});
`else
    applyStimulus(OP_MADDU, 32'd1, 32'd1, 1'b1, 1'b0);
    applyStimulus(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("maddu_off_busy", {63'd0, Busy}, 64'd0);
    repeat (6) @(negedge clk);
    checkOutput("maddu_off_hilo", {HI, LO}, {32'h00000000, 32'hFFFFFFFF});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
